// File: rtl/led_pwm_fader.sv
// LED PWM fader: per-channel duty ramps toward full/off targets set by the
// colour code, producing cross-faded PWM drive on three LED pins.
module led_pwm_fader #(
    parameter int PRESCALE = 4,
    parameter int STEP     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] colour,
    input  logic       enable,
    output logic [2:0] pwm,
    output logic       settled
);

    localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);
    localparam logic [7:0]  STEP8   = 8'(STEP);

    logic [2:0]       colour_q;
    logic [7:0]       pwm_cnt;
    logic [15:0]      pre_cnt;
    logic [2:0][7:0]  duty;
    logic [2:0]       at_target;
    logic             tick;

    assign tick = enable && (pre_cnt == PRE_MAX);

    always_comb begin
        at_target = '0;
        for (int c = 0; c < 3; c++)
            at_target[c] = (duty[c] == (colour_q[c] ? 8'hFF : 8'h00));
    end

    assign settled = &at_target;

    // Upward sums are formed in 9 bits so a full channel saturates rather
    // than wrapping back toward dark.
    function automatic logic [7:0] ramp(input logic [7:0] d, input logic up);
        logic [8:0] sum;
        sum = {1'b0, d} + {1'b0, STEP8};
        if (up)
            ramp = sum[8] ? 8'hFF : sum[7:0];
        else
            ramp = (d > STEP8) ? d - STEP8 : 8'h00;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            colour_q <= '0;
            pwm_cnt  <= '0;
            pre_cnt  <= '0;
            duty     <= '0;
            pwm      <= '0;
        end else begin
            colour_q <= colour;
            pwm_cnt  <= pwm_cnt + 8'd1;
            if (enable)
                pre_cnt <= tick ? 16'd0 : pre_cnt + 16'd1;
            for (int c = 0; c < 3; c++) begin
                pwm[c] <= enable && (duty[c] > pwm_cnt);
                if (tick && !at_target[c])
                    duty[c] <= ramp(duty[c], colour_q[c]);
            end
        end
    end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Randomized scoreboard bench for led_pwm_fader against an arithmetic
// reference model of the fader.
module tb_led_pwm_fader;

    localparam int P = 4;
    localparam int S = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] colour = 3'b001;
    logic       enable = 1'b1;
    logic [2:0] pwm;
    logic       settled;

    int checks = 0;
    int fails  = 0;

    led_pwm_fader #(.PRESCALE(P), .STEP(S)) dut (
        .clk(clk), .rst(rst), .colour(colour), .enable(enable),
        .pwm(pwm), .settled(settled)
    );

    always #5 clk = ~clk;

    // Reference model: integer state, updated from the inputs seen at each edge
    int m_duty[3];
    int m_col  = 0;
    int m_cnt  = 0;
    int m_pre  = 0;
    int m_pwm[3];
    logic [3:0] expq[$];

    initial begin
        for (int c = 0; c < 3; c++) begin
            m_duty[c] = 0;
            m_pwm[c]  = 0;
        end
    end

    always @(posedge clk) begin
        int  tgt;
        bit  tk;
        bit  st;
        logic [3:0] e;
        if (rst) begin
            m_col = 0; m_cnt = 0; m_pre = 0;
            for (int c = 0; c < 3; c++) begin
                m_duty[c] = 0;
                m_pwm[c]  = 0;
            end
        end else begin
            tk = enable && (m_pre == P - 1);
            for (int c = 0; c < 3; c++) begin
                m_pwm[c] = (enable && (m_duty[c] > m_cnt)) ? 1 : 0;
                tgt = ((m_col >> c) & 1) ? 255 : 0;
                if (tk) begin
                    if (m_duty[c] < tgt)
                        m_duty[c] = (m_duty[c] + S > 255) ? 255 : m_duty[c] + S;
                    else if (m_duty[c] > tgt)
                        m_duty[c] = (m_duty[c] > S) ? m_duty[c] - S : 0;
                end
            end
            m_col = int'(colour);
            m_cnt = (m_cnt + 1) % 256;
            if (enable)
                m_pre = tk ? 0 : m_pre + 1;
        end
        st = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (m_duty[c] < 0 || m_duty[c] > 255) st = 1'b0;
            if (m_duty[c] != ((((m_col >> c) & 1) != 0) ? 255 : 0)) st = 1'b0;
        end
        e = {m_pwm[2][0], m_pwm[1][0], m_pwm[0][0], st};
        expq.push_back(e);
    end

    // Monitor: pops one expectation per edge and compares
    always @(posedge clk) begin
        logic [3:0] e;
        #1;
        checks++;
        if (expq.size() == 0) begin
            fails++;
            $display("FAIL scoreboard_empty at %0t", $time);
        end else begin
            e = expq.pop_front();
            if ({pwm, settled} !== e) begin
                fails++;
                $display("FAIL pwm_settled at %0t: got pwm=%b settled=%b want pwm=%b settled=%b",
                         $time, pwm, settled, e[3:1], e[0]);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_settled(input string name, input int budget);
        int n;
        n = 0;
        while (!settled && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!settled) begin
            fails++;
            $display("FAIL %s: settled=%b after %0d cycles, want 1", name, settled, n);
        end
    endtask

    task automatic count_highs(input string name, input int want);
        int h;
        h = 0;
        repeat (256) begin
            @(posedge clk);
            #2;
            h += int'(pwm[0]);
        end
        checks++;
        if (h != want) begin
            fails++;
            $display("FAIL %s: highs=%0d want %0d", name, h, want);
        end
    endtask

    initial begin
        // Reset with colour=001 held
        cycles(2);
        checks++;
        if (pwm !== 3'b000 || settled !== 1'b1) begin
            fails++;
            $display("FAIL reset_state: pwm=%b settled=%b want 000/1", pwm, settled);
        end
        rst = 1'b0;
        cycles(2);
        checks++;
        if (settled !== 1'b0) begin
            fails++;
            $display("FAIL settled_drop: settled=%b want 0", settled);
        end
        wait_settled("full_ramp", 80);

        // Duty accuracy at both extremes
        count_highs("duty255_highs", 255);
        colour = 3'b000;
        cycles(2);
        wait_settled("fade_out", 80);
        count_highs("duty0_highs", 0);

        // Reversal mid-ramp
        colour = 3'b001;
        cycles(1 + 5 * P);
        colour = 3'b000;
        wait_settled("reversal", 80);

        // Enable pause mid-ramp
        colour = 3'b111;
        cycles(10);
        enable = 1'b0;
        cycles(2);
        checks++;
        if (pwm !== 3'b000) begin
            fails++;
            $display("FAIL pause_dark: pwm=%b want 000", pwm);
        end
        cycles(98);
        enable = 1'b1;
        wait_settled("resume", 80);

        // Reset pulse mid-ramp
        colour = 3'b010;
        cycles(20);
        rst = 1'b1;
        cycles(1);
        checks++;
        if (pwm !== 3'b000 || settled !== 1'b1) begin
            fails++;
            $display("FAIL midramp_reset: pwm=%b settled=%b want 000/1", pwm, settled);
        end
        rst = 1'b0;

        // Randomized colour, enable and rare reset
        repeat (120) begin
            colour = 3'($urandom_range(0, 7));
            enable = ($urandom_range(0, 5) != 0);
            rst    = ($urandom_range(0, 30) == 0);
            cycles($urandom_range(1, 40));
            rst = 1'b0;
        end
        enable = 1'b1;

        // Sequencer stepping every cycle, then hold
        for (int i = 0; i < 300; i++) begin
            colour = 3'((i % 6) + 1);
            cycles(1);
        end
        wait_settled("after_chain", 80);
        cycles(3);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/led_pwm_fader.md
# led_pwm_fader

Downstream stage of the dynamic LED colour sequencer. Consumes its 3-bit `colour` code (one bit per R/G/B channel) and drives three PWM LED pins. Channel brightness ramps linearly between off and full instead of switching instantly, so colour changes cross-fade. Free-running 8-bit PWM, per-channel 8-bit duty registers, prescaled ramp ticks.

## Interface
- `PRESCALE`, default 4: clocks per ramp tick; legal range 1..65535.
- `STEP`, default 16: duty increment/decrement per tick; legal range 1..255.

- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `colour`  in  3  target colour from sequencer; bit0=R, bit1=G, bit2=B; all 8 codes accepted.
- `enable`  in  1  1 = ramp and PWM active; 0 = outputs dark, state frozen.
- `pwm`  out  3  per-channel PWM drive, registered.
- `settled`  out  1  1 when every channel's duty equals its target.

## Operation
- `colour_q`: `colour` registered every cycle. Target per channel `target[c] = colour_q[c] ? 8'hFF : 8'h00`.
- `pwm_cnt`: 8-bit, +1 every cycle regardless of `enable`; wraps 255->0.
- `pre_cnt`: counts 0..PRESCALE-1 while `enable`=1; `tick` = (`pre_cnt`==PRESCALE-1 && `enable`). Wraps to 0 on tick. Held when `enable`=0.
- On `tick`, independently per channel:
  - duty < target: duty = min(duty+STEP, 255). Compute in 9 bits; saturate, never wrap.
  - duty > target: duty = (duty > STEP) ? duty-STEP : 0.
  - equal: unchanged.
- `pwm[c]` <= `enable` && (`duty[c]` > `pwm_cnt`). Duty 0 -> never high. Duty 255 -> high 255 of every 256 cycles. Duty d -> exactly d high cycles per 256-cycle PWM period.
- `settled` = (duty == target) for all three channels, combinational from registered state.
- Control states, derived from registers:
  - SETTLED: all duty == target.
  - RAMPING: any mismatch and `enable`=1.
  - PAUSED: `enable`=0.
- Transitions:
  - SETTLED->RAMPING on `colour_q` change.
  - RAMPING->SETTLED when the last channel reaches its target.
  - Any state->PAUSED on `enable`=0.
  - PAUSED->prior state on `enable`=1.
- Boundary rules:
  - Target change mid-ramp: direction reverses from the current duty. No duty jump, `pre_cnt` not restarted.
  - Several channels ramp simultaneously, each in its own direction (cross-fade).
  - `enable`=0: `pwm`=000 from the next edge. `duty`, `pre_cnt`, `colour_q` tracking unaffected except that duty is frozen.
  - `rst` mid-ramp: clears all state on that edge.

## Timing
- Reset values (edge with `rst`=1): `colour_q`=000, all duty=0, `pwm_cnt`=0, `pre_cnt`=0, `pwm`=000, hence `settled`=1.
- `colour` change at edge k -> `colour_q` at edge k+1; `settled` falls after edge k+1.
- First duty update at the first tick after edge k+1, within PRESCALE cycles.
- Full swing 0->255 takes ceil(255/STEP) ticks. Defaults: 16 ticks = 64 clocks.
- `pwm` reflects a duty/`pwm_cnt` pair one cycle after that pair exists (registered output).
- `settled` rises in the same cycle the final duty update becomes visible.

## Test plan
- Reset: `rst`=1 for 2 cycles with `colour`=001 -> `pwm`=000, `settled`=1. Release -> `settled`=0 from the 2nd edge after release. duty[0] reaches 255 after 16 ticks (~66 clocks), then `settled`=1 and `pwm[2:1]` stays 00.
- Duty accuracy: `colour`=001 settled, `pwm_cnt` aligned -> count `pwm[0]` highs over 256 cycles = 255. Force `colour`=000 and wait to settle -> 0 highs.
- Reversal: 000->001, after 5 ticks duty[0]=80. Switch `colour` to 000 -> duty 64,48,32,16,0 on the next 5 ticks, then `settled`=1. No value above 80 appears.
- Saturation: STEP=100, 000->111 -> each duty 100,200,255 (no wrap to 44). Back to 000 -> 155,55,0.
- Enable/reset: mid-ramp, `enable`=0 for 100 cycles -> `pwm`=000, duty frozen. Re-enable -> ramp resumes from the frozen value. Mid-ramp `rst` pulse -> duty=0 and `pwm`=000 after that edge.
- Chained with the sequencer: `button` held, `colour` stepping 001->010->...->110->001 every cycle -> no duty ever exceeds 255 or goes below 0. After `button` drops, `settled`=1 within 16 ticks.
